// File: rtl/riot_pkg.sv
// Shared definitions for the RIOT interval timer: CPU-visible register
// addresses, the 2-bit interval-select encoding with its prescale terminal
// counts, and the counter mode.
package riot_pkg;

  // Read-side registers
  localparam logic [6:0] ADR_INTIM  = 7'h04;
  localparam logic [6:0] ADR_TIMINT = 7'h05;

  // Write-side timer registers (interrupt disabled); +IRQ_EN_OFS enables irq
  localparam logic [6:0] ADR_TIM1T  = 7'h14;
  localparam logic [6:0] ADR_TIM8T  = 7'h15;
  localparam logic [6:0] ADR_TIM64T = 7'h16;
  localparam logic [6:0] ADR_T1024T = 7'h17;
  localparam logic [6:0] IRQ_EN_OFS = 7'h08;

  // Low two address bits of a timer write select the interval
  typedef enum logic [1:0] {
    IVL_1    = 2'd0,
    IVL_8    = 2'd1,
    IVL_64   = 2'd2,
    IVL_1024 = 2'd3
  } ivl_sel_e;

  typedef enum logic {
    MODE_INTERVAL  = 1'b0,
    MODE_UNDERFLOW = 1'b1
  } mode_e;

  // Prescale count value at which INTIM decrements (interval - 1)
  function automatic logic [9:0] ivl_terminal(ivl_sel_e sel);
    logic [9:0] term;
    case (sel)
      IVL_1:   term = 10'd0;
      IVL_8:   term = 10'd7;
      IVL_64:  term = 10'd63;
      default: term = 10'd1023;
    endcase
    return term;
  endfunction

  // Full 7-bit decode of 0x14..0x17 and 0x1C..0x1F: bits 1:0 pick the
  // interval and bit 3 the irq enable; all other bits must match exactly.
  function automatic logic is_timer_wr_adr(logic [6:0] adr);
    return (adr & ~(IRQ_EN_OFS | 7'h03)) == ADR_TIM1T;
  endfunction

endpackage

// File: rtl/wb_riot_timer_if.sv
// Wishbone slave bus bundle for the RIOT timer.
//   stb_i  strobe            we_i   write enable
//   adr_i  7-bit address     dat_i  write data
//   ack_o  acknowledge       dat_o  registered read data
interface wb_riot_timer_if;
  logic       stb_i;
  logic       we_i;
  logic [6:0] adr_i;
  logic [7:0] dat_i;
  logic       ack_o;
  logic [7:0] dat_o;

  modport master (
    output stb_i, we_i, adr_i, dat_i,
    input  ack_o, dat_o
  );

  modport slave (
    input  stb_i, we_i, adr_i, dat_i,
    output ack_o, dat_o
  );
endinterface

// File: rtl/riot_tick_gen.sv
// Free-running phi2 emulation divider: tick_o is high for exactly one clk_i
// cycle out of every PHI_DIV (1..255). Only reset restarts the phase.
//   clk_i   system clock
//   rst_i   asynchronous active-low reset
//   tick_o  one-cycle RIOT tick strobe
module riot_tick_gen #(
  parameter int unsigned PHI_DIV = 13
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam logic [7:0] DIV_LAST = 8'(PHI_DIV - 1);

  logic [7:0] div_q;

  assign tick_o = (div_q == DIV_LAST);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      div_q <= '0;
    end else if (tick_o) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 8'd1;
    end
  end

endmodule

// File: rtl/wb_riot_timer.sv
// Atari 2600 PIA (6532 RIOT) interval timer behind a Wishbone slave.
// INTIM counts down once per selected interval (1/8/64/1024 ticks); on
// underflow it sets TIMINT and switches to one decrement per tick until the
// next timer write.
//   clk_i   system clock
//   rst_i   asynchronous active-low reset
//   wb      Wishbone slave (stb/we/adr/dat_i in, ack/dat_o out)
//   irq_o   registered level interrupt = flag && irq_en
module wb_riot_timer
  import riot_pkg::*;
#(
  parameter int unsigned PHI_DIV = 13
) (
  input  logic             clk_i,
  input  logic             rst_i,
  wb_riot_timer_if.slave   wb,
  output logic             irq_o
);

  logic       tick;
  logic       valid_cmd;
  logic       timer_wr;
  logic       rd_intim;
  logic [7:0] rd_data;

  logic [7:0] intim_q,  intim_d;
  logic [9:0] presc_q,  presc_d;
  ivl_sel_e   sel_q,    sel_d;
  logic       irq_en_q, irq_en_d;
  logic       flag_q,   flag_d;
  mode_e      mode_q,   mode_d;
  logic       dec;
  logic       underflow;

  riot_tick_gen #(.PHI_DIV(PHI_DIV)) u_tick_gen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .tick_o (tick)
  );

  assign valid_cmd = rst_i && wb.stb_i;
  assign timer_wr  = valid_cmd && wb.we_i && is_timer_wr_adr(wb.adr_i);
  assign rd_intim  = valid_cmd && !wb.we_i && (wb.adr_i == ADR_INTIM);

  // Read mux samples pre-update state, so a read racing an underflow
  // returns 0x00.
  always_comb begin
    rd_data = '0;
    if (!wb.we_i) begin
      case (wb.adr_i)
        ADR_INTIM:  rd_data = intim_q;
        ADR_TIMINT: rd_data = {flag_q, 7'b0};
        default:    rd_data = '0;
      endcase
    end
  end

  always_comb begin
    intim_d   = intim_q;
    presc_d   = presc_q;
    sel_d     = sel_q;
    irq_en_d  = irq_en_q;
    flag_d    = flag_q;
    mode_d    = mode_q;
    dec       = 1'b0;
    underflow = 1'b0;

    if (timer_wr) begin
      // A write on a tick cycle swallows that tick.
      intim_d  = wb.dat_i;
      presc_d  = '0;
      sel_d    = ivl_sel_e'(wb.adr_i[1:0]);
      irq_en_d = wb.adr_i[3];
      flag_d   = 1'b0;
      mode_d   = MODE_INTERVAL;
    end else begin
      if (tick) begin
        if (mode_q == MODE_UNDERFLOW) begin
          dec = 1'b1;
        end else if (presc_q == ivl_terminal(sel_q)) begin
          presc_d = '0;
          dec     = 1'b1;
        end else begin
          presc_d = presc_q + 10'd1;
        end
      end

      underflow = dec && (intim_q == 8'h00);
      if (dec) begin
        intim_d = intim_q - 8'd1;
      end

      // Flag set beats an INTIM read clear in the same cycle.
      if (underflow) begin
        flag_d = 1'b1;
        mode_d = MODE_UNDERFLOW;
      end else if (rd_intim) begin
        flag_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wb.ack_o <= 1'b0;
      wb.dat_o <= '0;
      irq_o    <= 1'b0;
      intim_q  <= '0;
      presc_q  <= '0;
      sel_q    <= IVL_1024;
      irq_en_q <= 1'b0;
      flag_q   <= 1'b0;
      mode_q   <= MODE_INTERVAL;
    end else begin
      wb.ack_o <= valid_cmd;
      if (valid_cmd) begin
        wb.dat_o <= rd_data;
      end
      irq_o    <= flag_q && irq_en_q;
      intim_q  <= intim_d;
      presc_q  <= presc_d;
      sel_q    <= sel_d;
      irq_en_q <= irq_en_d;
      flag_q   <= flag_d;
      mode_q   <= mode_d;
    end
  end

endmodule

// File: tb/tb_wb_riot_timer.sv
// Directed bench for wb_riot_timer: dut1 runs with PHI_DIV=1, dut2 with
// PHI_DIV=4. Times noted as t are edges elapsed since the last timer write.
module tb_wb_riot_timer;

  logic clk;
  logic rst_n;
  logic irq1, irq2;
  int unsigned n_vec;
  int unsigned n_err;

  wb_riot_timer_if bus1();
  wb_riot_timer_if bus2();

  wb_riot_timer #(.PHI_DIV(1)) dut1 (
    .clk_i (clk),
    .rst_i (rst_n),
    .wb    (bus1),
    .irq_o (irq1)
  );

  wb_riot_timer #(.PHI_DIV(4)) dut2 (
    .clk_i (clk),
    .rst_i (rst_n),
    .wb    (bus2),
    .irq_o (irq2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus cycle, started #1 after an edge; returns #1 after the next edge.
  task automatic bus_op(input int unsigned which, input logic we, input logic [6:0] adr,
                        input logic [7:0] d, output logic ack, output logic [7:0] q);
    if (which == 1) begin
      bus1.stb_i = 1'b1; bus1.we_i = we; bus1.adr_i = adr; bus1.dat_i = d;
    end else begin
      bus2.stb_i = 1'b1; bus2.we_i = we; bus2.adr_i = adr; bus2.dat_i = d;
    end
    @(posedge clk);
    #1;
    if (which == 1) begin
      ack = bus1.ack_o; q = bus1.dat_o; bus1.stb_i = 1'b0;
    end else begin
      ack = bus2.ack_o; q = bus2.dat_o; bus2.stb_i = 1'b0;
    end
  endtask

  task automatic rd(input int unsigned which, input logic [6:0] adr, input string tag,
                    input logic [7:0] exp);
    logic       ack;
    logic [7:0] q;
    bus_op(which, 1'b0, adr, 8'h00, ack, q);
    check({tag, "_ack"}, {7'b0, ack}, 8'h01);
    check(tag, q, exp);
  endtask

  task automatic wr(input int unsigned which, input logic [6:0] adr, input logic [7:0] d,
                    input string tag);
    logic       ack;
    logic [7:0] q;
    bus_op(which, 1'b1, adr, d, ack, q);
    check({tag, "_ack"}, {7'b0, ack}, 8'h01);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic       ack;
    logic [7:0] q;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus1.stb_i = 1'b0; bus1.we_i = 1'b0; bus1.adr_i = 7'h04; bus1.dat_i = 8'h00;
    bus2.stb_i = 1'b0; bus2.we_i = 1'b0; bus2.adr_i = 7'h04; bus2.dat_i = 8'h00;

    // Reset held with strobe toggling
    for (int i = 0; i < 5; i++) begin
      bus1.stb_i = ~bus1.stb_i;
      bus2.stb_i = ~bus2.stb_i;
      @(posedge clk);
      #1;
      check("rst_ack1", {7'b0, bus1.ack_o}, 8'h00);
      check("rst_dat1", bus1.dat_o, 8'h00);
      check("rst_irq1", {7'b0, irq1}, 8'h00);
      check("rst_ack2", {7'b0, bus2.ack_o}, 8'h00);
    end
    bus1.stb_i = 1'b0;
    bus2.stb_i = 1'b0;
    rst_n = 1'b1;
    rd(1, 7'h04, "rst_intim", 8'h00);
    rd(1, 7'h05, "rst_timint", 8'h00);

    // TIM64T countdown, ending in a read racing the underflow at t=256
    wr(1, 7'h16, 8'h03, "t64_wr");          // t=0
    idle(1);                                 // t=1
    rd(1, 7'h04, "t64_t1", 8'h03);          // t=2
    idle(61);                                // t=63
    rd(1, 7'h04, "t64_t63", 8'h03);
    rd(1, 7'h04, "t64_t64", 8'h02);         // t=65
    idle(63);
    rd(1, 7'h04, "t64_t128", 8'h01);        // t=129
    idle(63);
    rd(1, 7'h04, "t64_t192", 8'h00);        // t=193
    idle(62);                                // t=255
    rd(1, 7'h04, "race_intim", 8'h00);      // underflow on this edge
    rd(1, 7'h05, "race_timint", 8'h80);     // t=256
    rd(1, 7'h04, "t64_t257", 8'hFE);
    check("t64_noirq", {7'b0, irq1}, 8'h00);

    // Write collision: every cycle ticks at PHI_DIV=1, dut1 in underflow mode
    wr(1, 7'h17, 8'h10, "col_wr");          // t=0
    rd(1, 7'h05, "col_flag", 8'h00);
    rd(1, 7'h04, "col_t1", 8'h10);          // t=2
    idle(1021);                              // t=1023
    rd(1, 7'h04, "col_t1023", 8'h10);
    rd(1, 7'h04, "col_t1024", 8'h0F);

    // Interrupt path
    wr(1, 7'h1C, 8'h00, "irq_wr");          // t=0
    check("irq_t0", {7'b0, irq1}, 8'h00);
    idle(1);                                 // t=1, flag set this edge
    check("irq_t1", {7'b0, irq1}, 8'h00);
    idle(1);                                 // t=2
    check("irq_t2", {7'b0, irq1}, 8'h01);
    rd(1, 7'h04, "irq_intim", 8'hFE);       // clears flag at t=3
    check("irq_t3", {7'b0, irq1}, 8'h01);
    rd(1, 7'h05, "irq_timint", 8'h00);
    check("irq_t4", {7'b0, irq1}, 8'h00);
    rd(1, 7'h05, "irq_timint2", 8'h00);

    // Unmapped accesses
    wr(1, 7'h17, 8'h50, "unm_load");
    rd(1, 7'h04, "unm_pre", 8'h50);
    bus_op(1, 1'b1, 7'h7F, 8'hAA, ack, q);
    check("unm_wr_ack", {7'b0, ack}, 8'h01);
    rd(1, 7'h30, "unm_rd", 8'h00);
    check("unm_ack_drop", {7'b0, bus1.ack_o}, 8'h01);
    idle(1);
    check("unm_ack_once", {7'b0, bus1.ack_o}, 8'h00);
    bus1.stb_i = 1'b1; bus1.we_i = 1'b0; bus1.adr_i = 7'h30;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("held_ack", {7'b0, bus1.ack_o}, 8'h01);
      check("held_dat", bus1.dat_o, 8'h00);
    end
    bus1.stb_i = 1'b0;
    rd(1, 7'h04, "unm_post", 8'h50);
    rd(1, 7'h05, "unm_flag", 8'h00);

    // Prescaler with PHI_DIV=4, interval 8: 32 clocks per decrement
    wr(2, 7'h15, 8'h02, "div_wr");          // t=0
    idle(28);
    rd(2, 7'h04, "div_t28", 8'h02);         // t=29
    idle(3);
    rd(2, 7'h04, "div_t32", 8'h01);         // t=33
    idle(27);
    rd(2, 7'h04, "div_t60", 8'h01);         // t=61
    idle(3);
    rd(2, 7'h04, "div_t64", 8'h00);         // t=65
    idle(27);
    rd(2, 7'h05, "div_t92", 8'h00);         // t=93
    idle(3);
    rd(2, 7'h05, "div_t96", 8'h80);

    // Asynchronous reset in the middle of operation
    wr(2, 7'h1C, 8'h00, "ar_wr");
    idle(8);
    check("ar_irq_pre", {7'b0, irq2}, 8'h01);
    rd(2, 7'h05, "ar_timint_pre", 8'h80);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_irq", {7'b0, irq2}, 8'h00);
    check("ar_dat", bus2.dat_o, 8'h00);
    check("ar_ack", {7'b0, bus2.ack_o}, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rd(2, 7'h04, "ar_intim", 8'h00);
    rd(2, 7'h05, "ar_timint", 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
